dram_result_dump: RTL and testbench
===================================

// Module: dram_result_dump
// PURPOSE
//  Downstream of the multi-core processor top. Waits for proc_done (all cores finished).
//  Then reads a contiguous data-memory result region word by word.
//  Streams each word out over a valid/ready byte interface to the host link (UART TX / debug FIFO).
//  Owns data-memory read access only while dumping; the cores are idle by then.
// PARAMETERS
//  WIDTH      8        data/address width of data memory
//  BASE_ADDR  8'd128   first data-memory address dumped
//  DUMP_LEN   128      number of words dumped (0..2**WIDTH)
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  rst         in   1      synchronous, active-high reset
//  proc_done   in   1      high when all cores report finished (level)
//  dmem_rEn    out  1      data-memory read enable
//  dmem_addr   out  WIDTH  data-memory read address
//  dmem_data   in   WIDTH  data-memory read data, valid 1 cycle after dmem_rEn
//  out_valid   out  1      out_data holds a valid word
//  out_data    out  WIDTH  dumped word
//  out_ready   in   1      sink accepts word when out_valid && out_ready
//  dump_busy   out  1      dump in progress
//  dump_done   out  1      dump complete; held until proc_done falls
// BEHAVIOUR
//  Reset: state=IDLE; dmem_rEn=0, dmem_addr=0, out_valid=0, out_data=0, dump_busy=0, dump_done=0.
//    Word counter and checksum cleared.
//  FSM: IDLE -> RD -> WT -> SEND -> (RD | CSUM | DONE); DONE -> IDLE.
//  IDLE: start on a proc_done rising edge, using a registered previous value reset to 1.
//    proc_done already high out of reset does NOT start a dump.
//    On start: dump_busy=1 next cycle, counter=0; go to RD.
//    If DUMP_LEN=0, go straight to DONE (or CSUM when DUMP_CHECKSUM_EN is defined).
//  RD: dmem_rEn=1 for exactly 1 cycle, dmem_addr=BASE_ADDR+counter, truncated mod 2**WIDTH (wraps past 255).
//  WT: dmem_rEn=0; on the next edge, capture dmem_data into out_data, set out_valid=1, go to SEND.
//  SEND: out_valid and out_data stay stable until out_ready is sampled high.
//    On handshake: out_valid=0 and counter++.
//    Next state: RD if counter<DUMP_LEN, else CSUM or DONE.
//    Throughput is one word per 3 cycles with out_ready tied high.
//  DONE: dump_busy=0, dump_done=1; dump_done holds while proc_done=1.
//    proc_done low -> clear dump_done, go to IDLE, re-arm.
//  proc_done falling mid-dump is ignored; the dump always completes.
//  Counter is WIDTH+1 bits so that DUMP_LEN=2**WIDTH terminates.
//  out_ready high while out_valid=0 has no effect.
//  rst asserted in any state returns to reset values on the next edge.
//    A partially sent word is dropped; no handshake is completed.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined:
//    A WIDTH-bit running sum (mod 2**WIDTH) is accumulated over every accepted word.
//    After the last data word, state CSUM presents the sum on out_data with out_valid=1.
//    Same handshake as SEND, then go to DONE. Total transfers = DUMP_LEN+1.
//    DUMP_LEN=0 emits one checksum word of 0.
//  DUMP_CHECKSUM_EN undefined: no CSUM state, no accumulator; exactly DUMP_LEN transfers.
// STRUCTURE
//  Shared package proc_pkg: dump FSM state encoding (IDLE,RD,WT,SEND,CSUM,DONE).
//    Also the default result base address / length constants shared with the core programs.
//  Single module, no sub-module: FSM, counter, capture register, checksum all inline.
//  At the processor top, dmem_rEn/dmem_addr are muxed with the controller only while dump_busy=1.
// TESTING
//  Reset values: hold rst 3 cycles with proc_done=1 -> all outputs 0.
//    Then no dump starts while proc_done stays 1.
//  Basic dump: mem[128..131]=8'h11,22,33,44, DUMP_LEN=4, out_ready=1, pulse proc_done 0->1.
//    -> out_data 11,22,33,44 in order, 4 handshakes, then dump_done=1.
//  Backpressure: out_ready low 10 cycles during word 2.
//    -> out_valid=1 and out_data=8'h22 stable throughout; no dmem_rEn pulses during the stall.
//  Wrap: BASE_ADDR=8'd254, DUMP_LEN=4 -> dmem_addr sequence 254,255,0,1.
//  Mid-op reset: assert rst after 2 of 4 words.
//    -> idle outputs next cycle; a new proc_done edge restarts from BASE_ADDR.
//  Checksum (macro defined): words 8'hF0,8'h20 -> third transfer 8'h10; DUMP_LEN=0 -> single 8'h00.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor-top definitions: result-dump FSM encoding and the result
// region location that the core programs write into.
package proc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WT,
      S_SEND,
      S_CSUM,
      S_DONE
   } dump_state_e;

   localparam logic [7:0] RESULT_BASE_ADDR = 8'd128;
   localparam int         RESULT_LEN       = 128;

endpackage

// File: rtl/dram_result_dump.sv
// Streams the data-memory result region to the host link once the cores finish.
// Define DUMP_CHECKSUM_EN to append a mod-2**WIDTH sum of all words as a final transfer.
module dram_result_dump
   import proc_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] BASE_ADDR = RESULT_BASE_ADDR,
   parameter int               DUMP_LEN  = RESULT_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             proc_done,
   output logic             dmem_rEn,
   output logic [WIDTH-1:0] dmem_addr,
   input  logic [WIDTH-1:0] dmem_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             dump_busy,
   output logic             dump_done
);

   // One extra bit so a full 2**WIDTH-word dump can still reach its terminal count.
   localparam logic [WIDTH:0] LEN = DUMP_LEN[WIDTH:0];

   dump_state_e      state_q, state_d;
   logic             pd_prev_q, pd_prev_d;
   logic [WIDTH:0]   cnt_q, cnt_d, cnt_inc;
   logic             ren_q, ren_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             hs;
`ifdef DUMP_CHECKSUM_EN
   logic [WIDTH-1:0] csum_q, csum_d, csum_nxt;
`endif

   always_comb begin
      state_d   = state_q;
      pd_prev_d = proc_done;
      cnt_d     = cnt_q;
      ren_d     = 1'b0;
      addr_d    = addr_q;
      valid_d   = valid_q;
      data_d    = data_q;
      busy_d    = busy_q;
      done_d    = done_q;
      hs        = valid_q && out_ready;
      cnt_inc   = cnt_q + 1'b1;
`ifdef DUMP_CHECKSUM_EN
      csum_d    = csum_q;
      csum_nxt  = csum_q + data_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (proc_done && !pd_prev_q) begin
               busy_d = 1'b1;
               cnt_d  = '0;
`ifdef DUMP_CHECKSUM_EN
               csum_d = '0;
`endif
               if (LEN == '0) begin
`ifdef DUMP_CHECKSUM_EN
                  state_d = S_CSUM;
                  valid_d = 1'b1;
                  data_d  = '0;
`else
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = S_RD;
                  ren_d   = 1'b1;
                  addr_d  = BASE_ADDR;
               end
            end
         end
         S_RD: state_d = S_WT;
         S_WT: begin
            data_d  = dmem_data;
            valid_d = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (hs) begin
               valid_d = 1'b0;
               cnt_d   = cnt_inc;
`ifdef DUMP_CHECKSUM_EN
               csum_d  = csum_nxt;
`endif
               if (cnt_inc < LEN) begin
                  state_d = S_RD;
                  ren_d   = 1'b1;
                  addr_d  = BASE_ADDR + cnt_inc[WIDTH-1:0];
               end else begin
`ifdef DUMP_CHECKSUM_EN
                  state_d = S_CSUM;
                  valid_d = 1'b1;
                  data_d  = csum_nxt;
`else
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`endif
               end
            end
         end
         S_CSUM: begin
            if (hs) begin
               valid_d = 1'b0;
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            if (!proc_done) begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Previous proc_done resets high so a level already asserted out of reset is not an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pd_prev_q <= 1'b1;
         cnt_q     <= '0;
         ren_q     <= 1'b0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pd_prev_q <= pd_prev_d;
         cnt_q     <= cnt_d;
         ren_q     <= ren_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign dmem_rEn  = ren_q;
   assign dmem_addr = addr_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign dump_busy = busy_q;
   assign dump_done = done_q;

endmodule

// File: tb/tb_dram_result_dump.sv
// Bench for dram_result_dump: four instances (base/length variants) share stimulus and are
// checked against a word list computed directly from the memory image.
module tb_dram_result_dump;

   localparam int N = 4;
`ifdef DUMP_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic clk = 1'b0, rst = 1'b1, proc_done = 1'b1, out_ready = 1'b0;
   logic [N-1:0]      ren, ov, busy, done;
   logic [N-1:0][7:0] addr, rdata, od;
   logic [7:0] mem [256];

   int tests = 0, fails = 0, cyc = 0;
   logic [7:0] got_d [N][1024];
   int         got_c [N][1024];
   logic [7:0] got_a [N][1024];
   int         got_n [N] = '{default: 0};
   int         addr_n [N] = '{default: 0};
   int         s_n [N], s_a [N];
   logic [7:0] exp_w [N][300];
   logic [7:0] exp_a [N][300];
   int         exp_n [N];

   always #5 clk = ~clk;

   function automatic int base_of(input int i);
      return (i == 1) ? 254 : 128;
   endfunction

   function automatic int len_of(input int i);
      return (i == 2) ? 0 : ((i == 3) ? 2 : 4);
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      dram_result_dump #(
         .WIDTH    (8),
         .BASE_ADDR((g == 1) ? 8'd254 : 8'd128),
         .DUMP_LEN ((g == 2) ? 0 : ((g == 3) ? 2 : 4))
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .proc_done(proc_done),
         .dmem_rEn (ren[g]),
         .dmem_addr(addr[g]),
         .dmem_data(rdata[g]),
         .out_valid(ov[g]),
         .out_data (od[g]),
         .out_ready(out_ready),
         .dump_busy(busy[g]),
         .dump_done(done[g])
      );
   end

   // Synchronous-read memory per instance plus handshake / read-address recorders.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (ren[i]) begin
            rdata[i] <= mem[addr[i]];
            if (addr_n[i] < 1024) got_a[i][addr_n[i]] <= addr[i];
            addr_n[i] <= addr_n[i] + 1;
         end
         if (ov[i] && out_ready) begin
            if (got_n[i] < 1024) begin
               got_d[i][got_n[i]] <= od[i];
               got_c[i][got_n[i]] <= cyc;
            end
            got_n[i] <= got_n[i] + 1;
         end
      end
   end

   // Reference: the region words in order, optionally followed by their byte sum.
   task automatic model_expect();
      for (int i = 0; i < N; i++) begin
         int b = base_of(i), l = len_of(i), sum = 0;
         for (int k = 0; k < l; k++) begin
            exp_a[i][k] = 8'((b + k) % 256);
            exp_w[i][k] = mem[(b + k) % 256];
            sum = (sum + int'(mem[(b + k) % 256])) % 256;
         end
         exp_n[i] = l;
         if (CS == 1) begin
            exp_w[i][l] = 8'(sum);
            exp_n[i] = l + 1;
         end
      end
   endtask

   task automatic snap();
      for (int i = 0; i < N; i++) begin
         s_n[i] = got_n[i];
         s_a[i] = addr_n[i];
      end
   endtask

   task automatic start_dump();
      proc_done = 1'b0;
      @(negedge clk);
      proc_done = 1'b1;
   endtask

   task automatic wait_all_done(input string name, input bit rnd);
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (done == '1) break;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      tests++;
      if (done !== '1) begin
         fails++;
         $display("FAIL %s_timeout: dump_done=%b want %b", name, done, {N{1'b1}});
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      proc_done = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({ren, ov, busy, done} !== '0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 0", {ren, ov, busy, done});
      end
      tests++;
      if ({addr, od} !== '0) begin
         fails++;
         $display("FAIL reset_data: got %h want 0", {addr, od});
      end
      rst = 1'b0;
      snap();
      repeat (10) @(negedge clk);
      tests++;
      if (addr_n[0] != s_a[0] || busy !== '0 || ov !== '0) begin
         fails++;
         $display("FAIL reset_no_start: reads %0d busy %b valid %b want 0/0/0",
                  addr_n[0] - s_a[0], busy, ov);
      end
   endtask

   task automatic test_basic();
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      mem[128] = 8'h11; mem[129] = 8'h22; mem[130] = 8'h33; mem[131] = 8'h44;
      out_ready = 1'b1;
      model_expect();
      snap();
      start_dump();
      @(negedge clk);
      tests++;
      if (busy[0] !== 1'b1) begin
         fails++;
         $display("FAIL basic_busy: got %b want 1", busy[0]);
      end
      wait_all_done("basic", 1'b0);
      for (int i = 0; i < N; i++) begin
         tests++;
         if (got_n[i] - s_n[i] != exp_n[i]) begin
            fails++;
            $display("FAIL basic_count[%0d]: got %0d want %0d", i, got_n[i] - s_n[i], exp_n[i]);
         end
         for (int k = 0; k < exp_n[i]; k++) begin
            tests++;
            if (got_d[i][s_n[i] + k] !== exp_w[i][k]) begin
               fails++;
               $display("FAIL basic_word[%0d][%0d]: got %h want %h", i, k, got_d[i][s_n[i] + k], exp_w[i][k]);
            end
         end
         tests++;
         if (addr_n[i] - s_a[i] != len_of(i)) begin
            fails++;
            $display("FAIL basic_reads[%0d]: got %0d want %0d", i, addr_n[i] - s_a[i], len_of(i));
         end
         for (int k = 0; k < len_of(i); k++) begin
            tests++;
            if (got_a[i][s_a[i] + k] !== exp_a[i][k]) begin
               fails++;
               $display("FAIL basic_addr[%0d][%0d]: got %0d want %0d", i, k, got_a[i][s_a[i] + k], exp_a[i][k]);
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (got_c[0][s_n[0] + k + 1] - got_c[0][s_n[0] + k] != 3) begin
            fails++;
            $display("FAIL basic_rate[%0d]: got %0d cycles want 3", k,
                     got_c[0][s_n[0] + k + 1] - got_c[0][s_n[0] + k]);
         end
      end
      repeat (5) @(negedge clk);
      tests++;
      if (done !== '1 || busy !== '0) begin
         fails++;
         $display("FAIL basic_done_hold: done %b busy %b want all-1/0", done, busy);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      out_ready = 1'b1;
      model_expect();
      snap();
      start_dump();
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (got_n[0] - s_n[0] == 1) begin ok = 1'b1; break; end
      end
      out_ready = 1'b0;
      for (int k = 0; k < 10 && ok; k++) begin
         if (ov[0]) break;
         @(negedge clk);
      end
      tests++;
      if (!ok || ov[0] !== 1'b1) begin
         fails++;
         $display("FAIL bp_reach_word2: valid %b seen1 %0d want 1/1", ov[0], ok);
      end
      s_a[0] = addr_n[0];
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         tests++;
         if (ov[0] !== 1'b1 || od[0] !== mem[129] || addr_n[0] != s_a[0]) begin
            fails++;
            $display("FAIL bp_stall[%0d]: valid %b data %h reads %0d want 1 %h 0",
                     k, ov[0], od[0], mem[129], addr_n[0] - s_a[0]);
         end
      end
      out_ready = 1'b1;
      wait_all_done("bp", 1'b0);
      for (int i = 0; i < N; i++) begin
         tests++;
         if (got_n[i] - s_n[i] != exp_n[i]) begin
            fails++;
            $display("FAIL bp_count[%0d]: got %0d want %0d", i, got_n[i] - s_n[i], exp_n[i]);
         end
         for (int k = 0; k < exp_n[i]; k++) begin
            tests++;
            if (got_d[i][s_n[i] + k] !== exp_w[i][k]) begin
               fails++;
               $display("FAIL bp_word[%0d][%0d]: got %h want %h", i, k, got_d[i][s_n[i] + k], exp_w[i][k]);
            end
         end
      end
   endtask

   task automatic test_random_ready();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
         model_expect();
         snap();
         start_dump();
         wait_all_done("rand", 1'b1);
         for (int i = 0; i < N; i++) begin
            tests++;
            if (got_n[i] - s_n[i] != exp_n[i]) begin
               fails++;
               $display("FAIL rand_count[%0d][%0d]: got %0d want %0d", r, i, got_n[i] - s_n[i], exp_n[i]);
            end
            for (int k = 0; k < exp_n[i]; k++) begin
               tests++;
               if (got_d[i][s_n[i] + k] !== exp_w[i][k]) begin
                  fails++;
                  $display("FAIL rand_word[%0d][%0d][%0d]: got %h want %h", r, i, k,
                           got_d[i][s_n[i] + k], exp_w[i][k]);
               end
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      out_ready = 1'b1;
      snap();
      start_dump();
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (got_n[0] - s_n[0] == 2) begin ok = 1'b1; break; end
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (!ok || {ren, ov, busy, done} !== '0 || {addr, od} !== '0) begin
         fails++;
         $display("FAIL midrst_idle: ctrl %b data %h seen2 %0d want 0 0 1",
                  {ren, ov, busy, done}, {addr, od}, ok);
      end
      rst = 1'b0;
      @(negedge clk);
      model_expect();
      snap();
      start_dump();
      wait_all_done("midrst", 1'b0);
      tests++;
      if (got_a[0][s_a[0]] !== 8'd128) begin
         fails++;
         $display("FAIL midrst_first_addr: got %0d want 128", got_a[0][s_a[0]]);
      end
      tests++;
      if (got_n[0] - s_n[0] != exp_n[0]) begin
         fails++;
         $display("FAIL midrst_count: got %0d want %0d", got_n[0] - s_n[0], exp_n[0]);
      end
      for (int k = 0; k < exp_n[0]; k++) begin
         tests++;
         if (got_d[0][s_n[0] + k] !== exp_w[0][k]) begin
            fails++;
            $display("FAIL midrst_word[%0d]: got %h want %h", k, got_d[0][s_n[0] + k], exp_w[0][k]);
         end
      end
   endtask

   task automatic test_checksum();
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      mem[128] = 8'hF0; mem[129] = 8'h20;
      out_ready = 1'b1;
      model_expect();
      snap();
      start_dump();
      wait_all_done("csum", 1'b0);
      for (int i = 2; i < N; i++) begin
         tests++;
         if (got_n[i] - s_n[i] != exp_n[i]) begin
            fails++;
            $display("FAIL csum_count[%0d]: got %0d want %0d", i, got_n[i] - s_n[i], exp_n[i]);
         end
      end
`ifdef DUMP_CHECKSUM_EN
      tests++;
      if (got_d[3][s_n[3] + 2] !== 8'h10) begin
         fails++;
         $display("FAIL csum_value: got %h want 10", got_d[3][s_n[3] + 2]);
      end
      tests++;
      if (got_d[2][s_n[2]] !== 8'h00) begin
         fails++;
         $display("FAIL csum_empty: got %h want 00", got_d[2][s_n[2]]);
      end
`else
      tests++;
      if (got_d[3][s_n[3] + 1] !== 8'h20) begin
         fails++;
         $display("FAIL csum_last_word: got %h want 20", got_d[3][s_n[3] + 1]);
      end
`endif
   endtask

   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      test_reset();
      test_basic();
      test_backpressure();
      test_random_ready();
      test_mid_reset();
      test_checksum();
      $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
      $finish;
   end

endmodule
